// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC generation, 1-cycle synchronous SRAM read,
// 1-entry skid buffer toward decode, redirect and halt handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        right_valid,
  input  logic        right_ready,
  output logic [31:0] Inst,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc_next, inflight_pc, skid_inst, skid_pc;
  logic        inflight, skid_valid;
  logic        right_fire, slot_free, stall_hit, issue;

  assign right_fire = right_valid & right_ready;
  assign slot_free  = ~right_valid | right_fire;
  // An in-flight response that will land on a stalled slot goes to the skid; a second
  // one would have nowhere to go, so hold off the request.
  assign stall_hit  = inflight & right_valid & ~right_ready;

  // Redirect flushes every buffer at the edge, so it may always issue.
  assign issue = reset & (redirect_valid | ((state == RUN) & ~skid_valid & ~stall_hit));

  assign inst_sram_en   = issue;
  assign inst_sram_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc_next     <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_inst   <= '0;
      skid_pc     <= '0;
      right_valid <= 1'b0;
      Inst        <= '0;
      PC          <= '0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt_req & ~redirect_valid) state <= HALT;
        HALT:    if (redirect_valid) state <= RUN;
        default: state <= BOOT;
      endcase

      inflight <= issue;
      if (issue) begin
        pc_next     <= inst_sram_addr + 32'd4;
        inflight_pc <= inst_sram_addr;
      end

      if (redirect_valid) begin
        // Stale output, skid and the response landing this cycle are all dropped.
        right_valid <= 1'b0;
        skid_valid  <= 1'b0;
      end else if (slot_free) begin
        if (skid_valid) begin
          Inst        <= skid_inst;
          PC          <= skid_pc;
          right_valid <= 1'b1;
          skid_valid  <= 1'b0;
        end else if (inflight) begin
          Inst        <= inst_sram_rdata;
          PC          <= inflight_pc;
          right_valid <= 1'b1;
        end else begin
          right_valid <= 1'b0;
        end
      end else if (inflight) begin
        skid_inst  <= inst_sram_rdata;
        skid_pc    <= inflight_pc;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: SRAM model, issue-order scoreboard on the decode side,
// directed boot/stall/redirect/halt/wrap/reset scenarios plus a random phase.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en;
  logic [31:0] addr;
  logic [31:0] rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        rv;
  logic        rr = 1'b1;
  logic [31:0] inst_o, pc_o;

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(en), .inst_sram_addr(addr), .inst_sram_rdata(rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .right_valid(rv), .right_ready(rr), .Inst(inst_o), .PC(pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3c5a96e1;
  endfunction

  always @(posedge clk) if (en) rdata <= inst_of(addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Reference: every issued fetch is expected at decode, in issue order, unless a
  // redirect flushes it; the fetch pointer follows reset/redirect/+4.
  logic [31:0] sb[$];
  logic [31:0] ptr = RESET_PC;
  logic        halted = 1'b0;
  logic        boot = 1'b1;

  always @(negedge clk) begin
    logic        halted_n;
    logic [31:0] exp_pc;
    if (!reset) begin
      sb.delete();
      ptr    = RESET_PC;
      halted = 1'b0;
      boot   = 1'b1;
    end else begin
      halted_n = halted;
      if (boot) chk("mon_boot_en", {31'd0, en}, 32'd0);
      if (rv && rr) begin
        fires++;
        chk("sb_underflow", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() > 0) begin
          exp_pc = sb.pop_front();
          chk("mon_pc", pc_o, exp_pc);
          chk("mon_inst", inst_o, inst_of(exp_pc));
        end
      end
      if (redirect_valid) begin
        sb.delete();
        ptr      = {redirect_pc[31:2], 2'b00};
        halted_n = 1'b0;
        chk("redir_en", {31'd0, en}, 32'd1);
      end else begin
        if (halted) chk("halt_en", {31'd0, en}, 32'd0);
        if (halt_req && !boot) halted_n = 1'b1;
      end
      if (en) begin
        chk("mon_addr", addr, ptr);
        sb.push_back(ptr);
        ptr = ptr + 32'd4;
      end
      halted = halted_n;
      boot   = 1'b0;
    end
  end

  // Entered at posedge+1 just after reset release with ready=1.
  task automatic boot_check();
    @(negedge clk); chk("boot_en", {31'd0, en}, 32'd0);
    nxt(); @(negedge clk);
    chk("first_en", {31'd0, en}, 32'd1);
    chk("first_addr", addr, RESET_PC);
    chk("first_rv", {31'd0, rv}, 32'd0);
    nxt(); @(negedge clk); chk("lat_rv", {31'd0, rv}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      nxt(); @(negedge clk);
      chk("seq_rv", {31'd0, rv}, 32'd1);
      chk("seq_pc", pc_o, RESET_PC + 32'(4 * k));
    end
    nxt();
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1'b1; redirect_pc = tgt; rr = 1'b1;
    @(negedge clk);
    chk("redir_addr", addr, {tgt[31:2], 2'b00});
    nxt();
    redirect_valid = 1'b0;
    @(negedge clk); chk("redir_bubble", {31'd0, rv}, 32'd0);
    nxt(); @(negedge clk);
    chk("redir_rv", {31'd0, rv}, 32'd1);
    chk("redir_pc0", pc_o, {tgt[31:2], 2'b00});
    nxt(); @(negedge clk);
    chk("redir_pc1", pc_o, {tgt[31:2], 2'b00} + 32'd4);
    nxt();
  endtask

  initial begin
    int f0;
    // T1: boot and back-to-back stream
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("reset_rv", {31'd0, rv}, 32'd0);
    boot_check();

    // T2: three stall cycles, output held, skid full blocks issue
    rr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_en", {31'd0, en}, 32'd0);
      chk("stall_rv", {31'd0, rv}, 32'd1);
      chk("stall_pc", pc_o, RESET_PC + 32'd12);
      nxt();
    end
    rr = 1'b1;
    repeat (4) nxt();

    // T3: redirect while stalled with skid full
    rr = 1'b0;
    repeat (3) nxt();
    redirect_to(32'h1c000103);

    // T4: halt pulse, then resume via redirect
    repeat (3) nxt();
    halt_req = 1'b1;
    nxt();
    halt_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("halted_en", {31'd0, en}, 32'd0);
      nxt();
    end
    redirect_to(32'h1c000200);

    // T5: wrap past the top of the address space
    redirect_to(32'hfffffffc);
    repeat (2) nxt();

    // Random phase
    f0 = fires;
    for (int i = 0; i < 3000; i++) begin
      rr             = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      halt_req       = ($urandom_range(0, 29) == 0);
      nxt();
    end
    halt_req = 1'b0;
    chk("liveness", (fires - f0 > 200) ? 32'd1 : 32'd0, 32'd1);
    redirect_to(32'h1c000400);

    // T6: asynchronous reset mid-stream, then restart at RESET_PC
    repeat (2) nxt();
    #2 reset = 1'b0;
    #1;
    chk("async_rv", {31'd0, rv}, 32'd0);
    chk("async_en", {31'd0, en}, 32'd0);
    chk("async_pc", pc_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    boot_check();
    repeat (10) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
